// File: rtl/stage_reg_skid_if.sv
// Handshake bundle for stage_reg_skid: producer side, consumer side, flush and occupancy.
// Parity ports exist only when STAGE_REG_PARITY_EN is defined.
interface stage_reg_skid_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 1
);
  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [1:0]                occupancy;
`ifdef STAGE_REG_PARITY_EN
  logic                      err_inject;
  logic [CHANNELS-1:0]       parity_err;
`endif

  modport master (
    output in_valid, in_data, flush, out_ready,
`ifdef STAGE_REG_PARITY_EN
    output err_inject,
    input  parity_err,
`endif
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
`ifdef STAGE_REG_PARITY_EN
    input  err_inject,
    output parity_err,
`endif
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/stage_reg_skid.sv
// Inter-stage register with a 2-entry skid buffer (main + skid), FIFO order, flush.
// Optional per-lane even parity with error injection: define STAGE_REG_PARITY_EN.
module stage_reg_skid #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      CHANNELS  = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic            CLK,
  input logic            Reset,
  stage_reg_skid_if.slave bus
);
  localparam int unsigned          BUS_W     = CHANNELS * WIDTH;
  localparam logic [BUS_W-1:0]     RESET_BUS = {CHANNELS{RESET_VAL}};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [BUS_W-1:0] main_q, skid_q;
  logic             in_ready, out_valid, accept, deliver;
  logic             load_main_in, load_skid_in, load_main_skid;

  // in_ready looks only at state and Reset, never at out_ready, so no comb path crosses the stage.
  assign in_ready  = (state != TWO) && !Reset;
  assign out_valid = (state != EMPTY);
  assign accept    = bus.in_valid && in_ready;
  assign deliver   = out_valid && bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = main_q;
  assign bus.occupancy = state;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_skid_in   = 1'b0;
    load_main_skid = 1'b0;
    unique case (state)
      EMPTY: if (accept) begin
        state_nxt    = ONE;
        load_main_in = 1'b1;
      end
      ONE: begin
        if (accept && deliver) begin
          load_main_in = 1'b1;
        end else if (deliver) begin
          state_nxt = EMPTY;
        end else if (accept) begin
          state_nxt    = TWO;
          load_skid_in = 1'b1;
        end
      end
      TWO: if (deliver) begin
        state_nxt      = ONE;
        load_main_skid = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
  end

`ifdef STAGE_REG_PARITY_EN
  logic [CHANNELS-1:0] in_par, main_par, skid_par, par_err;

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      in_par[k]  = ^bus.in_data[k*WIDTH +: WIDTH];
      par_err[k] = out_valid && ((^main_q[k*WIDTH +: WIDTH]) != main_par[k]);
    end
    in_par[0] = in_par[0] ^ bus.err_inject;
  end

  assign bus.parity_err = par_err;
`endif

  // Reset and flush both empty the stage; Reset wins only in that it also holds in_ready low.
  always_ff @(posedge CLK) begin
    if (Reset || bus.flush) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      state  <= EMPTY;
      main_q <= RESET_BUS;
      skid_q <= RESET_BUS;
`ifdef STAGE_REG_PARITY_EN
      main_par <= '0;
      skid_par <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (load_main_in) begin
        main_q <= bus.in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid_in) begin
        skid_q <= bus.in_data;
      end
`ifdef STAGE_REG_PARITY_EN
      if (load_main_in) begin
        main_par <= in_par;
      end else if (load_main_skid) begin
        main_par <= skid_par;
      end
      if (load_skid_in) begin
        skid_par <= in_par;
      end
`endif
    end
  end
endmodule
